// File: rtl/ls_queue_gen2.sv
// Load/store issue queue: in-order circular FIFO that wakes up operands from the CDB.
// Zero-latency issue from registered head state; dispatch is dropped while full, so hold it until not full.
module ls_queue_gen2 #(
    parameter int DEPTH      = 4,
    parameter int DATA_WIDTH = 32,
    parameter int TAG_WIDTH  = 6
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       flush,
    input  logic [DATA_WIDTH-1:0]      dispatch_rs1_data,
    input  logic [DATA_WIDTH-1:0]      dispatch_rs2_data,
    input  logic [TAG_WIDTH-1:0]       dispatch_rs1_tag,
    input  logic [TAG_WIDTH-1:0]       dispatch_rs2_tag,
    input  logic                       dispatch_rs1_data_val,
    input  logic                       dispatch_rs2_data_val,
    input  logic [DATA_WIDTH-1:0]      dispatch_imm,
    input  logic [1:0]                 dispatch_opcode,
    input  logic [TAG_WIDTH-1:0]       dispatch_rd_tag,
    input  logic                       dispatch_enable,
    input  logic [TAG_WIDTH-1:0]       cdb_tag,
    input  logic [DATA_WIDTH-1:0]      cdb_data,
    input  logic                       cdb_valid,
    output logic                       issueque_full,
    output logic                       issueque_empty,
    output logic [$clog2(DEPTH):0]     issueque_count,
    output logic                       issueque_ready,
    output logic [DATA_WIDTH-1:0]      issueque_address,
    output logic [DATA_WIDTH-1:0]      issueque_rs2_data,
    output logic [TAG_WIDTH-1:0]       issueque_rd_tag,
    output logic [1:0]                 issueque_opcode,
    input  logic                       issueblk_done
);
    localparam int IW = $clog2(DEPTH);
    localparam int PW = IW + 1;

    logic [PW-1:0]         r_wptr, r_rptr;
    logic [DEPTH-1:0]      r_ev, r_rs1_val, r_rs2_val;
    logic [DATA_WIDTH-1:0] r_rs1_data [DEPTH];
    logic [DATA_WIDTH-1:0] r_rs2_data [DEPTH];
    logic [DATA_WIDTH-1:0] r_imm      [DEPTH];
    logic [TAG_WIDTH-1:0]  r_rs1_tag  [DEPTH];
    logic [TAG_WIDTH-1:0]  r_rs2_tag  [DEPTH];
    logic [TAG_WIDTH-1:0]  r_rd_tag   [DEPTH];
    logic [1:0]            r_op       [DEPTH];

    logic [IW-1:0]         w_widx, w_ridx;
    logic                  w_full, w_empty, w_ready, w_push, w_pop;
    logic                  w_rs1_hit, w_rs2_hit;

    assign w_widx  = r_wptr[IW-1:0];
    assign w_ridx  = r_rptr[IW-1:0];
    assign w_full  = (w_widx == w_ridx) && (r_wptr[IW] != r_rptr[IW]);
    assign w_empty = (r_wptr == r_rptr);
    // Stores need both operands; loads only the address base.
    assign w_ready = r_ev[w_ridx] && r_rs1_val[w_ridx] && (!r_op[w_ridx][1] || r_rs2_val[w_ridx]);
    assign w_push  = dispatch_enable && !w_full;
    assign w_pop   = issueblk_done && w_ready;

    assign w_rs1_hit = cdb_valid && !dispatch_rs1_data_val && (cdb_tag == dispatch_rs1_tag);
    assign w_rs2_hit = cdb_valid && !dispatch_rs2_data_val && (cdb_tag == dispatch_rs2_tag);

    assign issueque_full     = w_full;
    assign issueque_empty    = w_empty;
    assign issueque_count    = r_wptr - r_rptr;
    assign issueque_ready    = w_ready;
    assign issueque_address  = r_rs1_data[w_ridx] + r_imm[w_ridx];
    assign issueque_rs2_data = r_rs2_data[w_ridx];
    assign issueque_rd_tag   = r_rd_tag[w_ridx];
    assign issueque_opcode   = r_op[w_ridx];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wptr    <= '0;
            r_rptr    <= '0;
            r_ev      <= '0;
            r_rs1_val <= '0;
            r_rs2_val <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_rs1_data[i] <= '0;
                r_rs2_data[i] <= '0;
                r_imm[i]      <= '0;
                r_rs1_tag[i]  <= '0;
                r_rs2_tag[i]  <= '0;
                r_rd_tag[i]   <= '0;
                r_op[i]       <= '0;
            end
        end else if (flush) begin
            r_wptr <= '0;
            r_rptr <= '0;
            r_ev   <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (r_ev[i] && cdb_valid) begin
                    if (!r_rs1_val[i] && (r_rs1_tag[i] == cdb_tag)) begin
                        r_rs1_data[i] <= cdb_data;
                        r_rs1_val[i]  <= 1'b1;
                    end
                    if (!r_rs2_val[i] && (r_rs2_tag[i] == cdb_tag)) begin
                        r_rs2_data[i] <= cdb_data;
                        r_rs2_val[i]  <= 1'b1;
                    end
                end
            end
            // The write slot is never occupied, so it cannot collide with the wakeup loop above.
            if (w_push) begin
                r_rs1_data[w_widx] <= w_rs1_hit ? cdb_data : dispatch_rs1_data;
                r_rs2_data[w_widx] <= w_rs2_hit ? cdb_data : dispatch_rs2_data;
                r_rs1_val[w_widx]  <= dispatch_rs1_data_val || w_rs1_hit;
                r_rs2_val[w_widx]  <= dispatch_rs2_data_val || w_rs2_hit;
                r_rs1_tag[w_widx]  <= dispatch_rs1_tag;
                r_rs2_tag[w_widx]  <= dispatch_rs2_tag;
                r_imm[w_widx]      <= dispatch_imm;
                r_rd_tag[w_widx]   <= dispatch_rd_tag;
                r_op[w_widx]       <= dispatch_opcode;
                r_ev[w_widx]       <= 1'b1;
                r_wptr             <= r_wptr + PW'(1);
            end
            if (w_pop) begin
                r_ev[w_ridx] <= 1'b0;
                r_rptr       <= r_rptr + PW'(1);
            end
        end
    end
endmodule

// File: tb/tb_ls_queue_gen2.sv
// Directed bench for ls_queue_gen2 with an issue scoreboard fed at dispatch and drained at issue.
module tb_ls_queue_gen2;
    logic        clk;
    logic        reset;
    logic        flush;
    logic [31:0] dispatch_rs1_data, dispatch_rs2_data, dispatch_imm;
    logic [5:0]  dispatch_rs1_tag, dispatch_rs2_tag, dispatch_rd_tag;
    logic        dispatch_rs1_data_val, dispatch_rs2_data_val, dispatch_enable;
    logic [1:0]  dispatch_opcode;
    logic [5:0]  cdb_tag;
    logic [31:0] cdb_data;
    logic        cdb_valid;
    logic        issueque_full, issueque_empty, issueque_ready;
    logic [2:0]  issueque_count;
    logic [31:0] issueque_address, issueque_rs2_data;
    logic [5:0]  issueque_rd_tag;
    logic [1:0]  issueque_opcode;
    logic        issueblk_done;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] rs2;
        logic [5:0]  rd;
        logic [1:0]  op;
    } exp_t;
    exp_t sb[$];

    int checks = 0;
    int errors = 0;

    ls_queue_gen2 #(.DEPTH(4), .DATA_WIDTH(32), .TAG_WIDTH(6)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .dispatch_rs1_data(dispatch_rs1_data), .dispatch_rs2_data(dispatch_rs2_data),
        .dispatch_rs1_tag(dispatch_rs1_tag), .dispatch_rs2_tag(dispatch_rs2_tag),
        .dispatch_rs1_data_val(dispatch_rs1_data_val), .dispatch_rs2_data_val(dispatch_rs2_data_val),
        .dispatch_imm(dispatch_imm), .dispatch_opcode(dispatch_opcode),
        .dispatch_rd_tag(dispatch_rd_tag), .dispatch_enable(dispatch_enable),
        .cdb_tag(cdb_tag), .cdb_data(cdb_data), .cdb_valid(cdb_valid),
        .issueque_full(issueque_full), .issueque_empty(issueque_empty),
        .issueque_count(issueque_count), .issueque_ready(issueque_ready),
        .issueque_address(issueque_address), .issueque_rs2_data(issueque_rs2_data),
        .issueque_rd_tag(issueque_rd_tag), .issueque_opcode(issueque_opcode),
        .issueblk_done(issueblk_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic disp(input logic [1:0] op, input logic [31:0] r1, input logic v1, input logic [5:0] t1,
                        input logic [31:0] r2, input logic v2, input logic [5:0] t2,
                        input logic [31:0] imm, input logic [5:0] rd);
        dispatch_opcode       = op;
        dispatch_rs1_data     = r1;
        dispatch_rs1_data_val = v1;
        dispatch_rs1_tag      = t1;
        dispatch_rs2_data     = r2;
        dispatch_rs2_data_val = v2;
        dispatch_rs2_tag      = t2;
        dispatch_imm          = imm;
        dispatch_rd_tag       = rd;
        dispatch_enable       = 1'b1;
    endtask

    task automatic ld(input logic [31:0] r1, input logic [31:0] imm, input logic [5:0] rd);
        disp(2'b00, r1, 1'b1, 6'd0, 32'h0, 1'b1, 6'd0, imm, rd);
    endtask

    task automatic push_exp(input logic [31:0] addr, input logic [31:0] rs2, input logic [5:0] rd, input logic [1:0] op);
        exp_t e;
        e.addr = addr; e.rs2 = rs2; e.rd = rd; e.op = op;
        sb.push_back(e);
    endtask

    // Inputs are stable at the falling edge, so a ready+done seen here issues on the next rising edge.
    always @(negedge clk) begin
        if (reset && !flush && issueque_ready && issueblk_done) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $error("FAIL unexpected_issue: observed issue of rd %0h, expected no issue", issueque_rd_tag);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("issue_addr", issueque_address, e.addr);
                chk("issue_rs2", issueque_rs2_data, e.rs2);
                chk("issue_rd", 32'(issueque_rd_tag), 32'(e.rd));
                chk("issue_op", 32'(issueque_opcode), 32'(e.op));
            end
        end
    end

    initial begin
        reset = 1'b0; flush = 1'b0; issueblk_done = 1'b0;
        dispatch_enable = 1'b0; dispatch_opcode = 2'b00;
        dispatch_rs1_data = '0; dispatch_rs2_data = '0; dispatch_imm = '0;
        dispatch_rs1_tag = '0; dispatch_rs2_tag = '0; dispatch_rd_tag = '0;
        dispatch_rs1_data_val = 1'b0; dispatch_rs2_data_val = 1'b0;
        cdb_tag = '0; cdb_data = '0; cdb_valid = 1'b0;

        tick(); tick();
        chk("rst_full", 32'(issueque_full), 32'd0);
        chk("rst_empty", 32'(issueque_empty), 32'd1);
        chk("rst_count", 32'(issueque_count), 32'd0);
        chk("rst_ready", 32'(issueque_ready), 32'd0);
        chk("rst_addr", issueque_address, 32'd0);
        reset = 1'b1;
        tick();
        chk("post_rst_empty", 32'(issueque_empty), 32'd1);

        // Fill with four ready loads, reject a fifth, then drain in order.
        for (int i = 0; i < 4; i++) begin
            ld(32'h1000 + 32'(i) * 32'h10, 32'(i), 6'(i + 1));
            push_exp(32'h1000 + 32'(i) * 32'h11, 32'h0, 6'(i + 1), 2'b00);
            tick();
        end
        dispatch_enable = 1'b0;
        chk("fill_full", 32'(issueque_full), 32'd1);
        chk("fill_count", 32'(issueque_count), 32'd4);
        chk("fill_ready", 32'(issueque_ready), 32'd1);
        ld(32'hDEAD0000, 32'h0, 6'd63);
        tick();
        dispatch_enable = 1'b0;
        chk("fifth_count", 32'(issueque_count), 32'd4);
        chk("fifth_head", issueque_address, 32'h1000);
        issueblk_done = 1'b1;
        repeat (4) tick();
        issueblk_done = 1'b0;
        chk("drain_empty", 32'(issueque_empty), 32'd1);
        chk("drain_count", 32'(issueque_count), 32'd0);
        chk("drain_ready", 32'(issueque_ready), 32'd0);

        // Load waits on tag 5, woken by the CDB.
        disp(2'b00, 32'h0, 1'b0, 6'd5, 32'h0, 1'b1, 6'd0, 32'h10, 6'd7);
        push_exp(32'h110, 32'h0, 6'd7, 2'b00);
        tick();
        dispatch_enable = 1'b0;
        chk("ld_wait_ready", 32'(issueque_ready), 32'd0);
        cdb_valid = 1'b1; cdb_tag = 6'd5; cdb_data = 32'h100;
        tick();
        cdb_valid = 1'b0;
        chk("ld_wake_ready", 32'(issueque_ready), 32'd1);
        chk("ld_wake_addr", issueque_address, 32'h110);
        issueblk_done = 1'b1; tick(); issueblk_done = 1'b0;

        // Store waits on rs2 tag 9; done alone and a foreign tag must not issue it.
        disp(2'b10, 32'h2000, 1'b1, 6'd0, 32'h0, 1'b0, 6'd9, 32'h4, 6'd8);
        push_exp(32'h2004, 32'hAB, 6'd8, 2'b10);
        tick();
        dispatch_enable = 1'b0;
        chk("st_wait_ready", 32'(issueque_ready), 32'd0);
        issueblk_done = 1'b1;
        cdb_valid = 1'b1; cdb_tag = 6'd10; cdb_data = 32'hCC;
        tick();
        issueblk_done = 1'b0; cdb_valid = 1'b0;
        chk("st_done_ignored", 32'(issueque_count), 32'd1);
        chk("st_other_tag", 32'(issueque_ready), 32'd0);
        cdb_valid = 1'b1; cdb_tag = 6'd9; cdb_data = 32'hAB;
        tick();
        cdb_valid = 1'b0;
        chk("st_wake_ready", 32'(issueque_ready), 32'd1);
        chk("st_wake_rs2", issueque_rs2_data, 32'hAB);
        issueblk_done = 1'b1; tick(); issueblk_done = 1'b0;

        // Operand captured from the CDB in the dispatch cycle.
        disp(2'b00, 32'h0, 1'b0, 6'd3, 32'h0, 1'b1, 6'd0, 32'h0, 6'd9);
        cdb_valid = 1'b1; cdb_tag = 6'd3; cdb_data = 32'h40;
        push_exp(32'h40, 32'h0, 6'd9, 2'b00);
        tick();
        dispatch_enable = 1'b0; cdb_valid = 1'b0;
        chk("byp_ready", 32'(issueque_ready), 32'd1);
        chk("byp_addr", issueque_address, 32'h40);
        issueblk_done = 1'b1; tick(); issueblk_done = 1'b0;

        // Address addition wraps without carry.
        ld(32'hFFFFFFF0, 32'h20, 6'd11);
        push_exp(32'h10, 32'h0, 6'd11, 2'b00);
        tick();
        dispatch_enable = 1'b0;
        chk("wrap_addr", issueque_address, 32'h10);
        issueblk_done = 1'b1; tick(); issueblk_done = 1'b0;

        // Simultaneous dispatch and issue, full and half-full.
        for (int i = 0; i < 4; i++) begin
            ld(32'h3000 + 32'(i), 32'h0, 6'(20 + i));
            push_exp(32'h3000 + 32'(i), 32'h0, 6'(20 + i), 2'b00);
            tick();
        end
        ld(32'h4000, 32'h0, 6'd30);
        issueblk_done = 1'b1;
        tick();
        dispatch_enable = 1'b0;
        chk("full_both_count", 32'(issueque_count), 32'd3);
        tick();
        issueblk_done = 1'b0;
        chk("half_count", 32'(issueque_count), 32'd2);
        ld(32'h4100, 32'h0, 6'd31);
        push_exp(32'h4100, 32'h0, 6'd31, 2'b00);
        issueblk_done = 1'b1;
        tick();
        dispatch_enable = 1'b0; issueblk_done = 1'b0;
        chk("half_both_count", 32'(issueque_count), 32'd2);
        issueblk_done = 1'b1;
        repeat (2) tick();
        issueblk_done = 1'b0;
        chk("half_drain_empty", 32'(issueque_empty), 32'd1);

        // Flush at count 3 overrides a coincident dispatch and issue.
        for (int i = 0; i < 3; i++) begin
            ld(32'h5000 + 32'(i), 32'h0, 6'(40 + i));
            push_exp(32'h5000 + 32'(i), 32'h0, 6'(40 + i), 2'b00);
            tick();
        end
        dispatch_enable = 1'b0;
        chk("pre_flush_count", 32'(issueque_count), 32'd3);
        ld(32'h6000, 32'h0, 6'd50);
        issueblk_done = 1'b1; flush = 1'b1;
        tick();
        dispatch_enable = 1'b0; issueblk_done = 1'b0; flush = 1'b0;
        sb.delete();
        chk("flush_empty", 32'(issueque_empty), 32'd1);
        chk("flush_count", 32'(issueque_count), 32'd0);
        chk("flush_ready", 32'(issueque_ready), 32'd0);

        // Reset asserted in the middle of a dispatch cycle.
        ld(32'h7000, 32'h0, 6'd60);
        #2;
        reset = 1'b0;
        #1;
        chk("midrst_count", 32'(issueque_count), 32'd0);
        chk("midrst_empty", 32'(issueque_empty), 32'd1);
        tick();
        dispatch_enable = 1'b0;
        reset = 1'b1;
        tick();
        chk("after_rst_count", 32'(issueque_count), 32'd0);
        chk("after_rst_ready", 32'(issueque_ready), 32'd0);

        ld(32'h500, 32'h5, 6'd12);
        push_exp(32'h505, 32'h0, 6'd12, 2'b00);
        tick();
        dispatch_enable = 1'b0;
        chk("after_rst_disp", 32'(issueque_count), 32'd1);
        issueblk_done = 1'b1; tick(); issueblk_done = 1'b0;
        chk("final_empty", 32'(issueque_empty), 32'd1);
        chk("sb_drained", 32'(sb.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
